// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 encryption datapath.
// After a load it runs one initial AddRoundKey cycle, then NR round cycles.
// It drives the datapath enables, the init/round mux select, the MixColumns
// bypass and the key-expansion round constant, and flags completion with done.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic       init_sel,
    output logic       state_en,
    output logic       key_en,
    output logic       mix_en,
    output logic [7:0] rcon
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] round_q, round_nxt;

    // Key-expansion round constants for rounds 1..10; anything else is zero.
    function automatic logic [7:0] rc_of(input logic [3:0] r);
        case (r)
            4'd1:    rc_of = 8'h01;
            4'd2:    rc_of = 8'h02;
            4'd3:    rc_of = 8'h04;
            4'd4:    rc_of = 8'h08;
            4'd5:    rc_of = 8'h10;
            4'd6:    rc_of = 8'h20;
            4'd7:    rc_of = 8'h40;
            4'd8:    rc_of = 8'h80;
            4'd9:    rc_of = 8'h1b;
            4'd10:   rc_of = 8'h36;
            default: rc_of = 8'h00;
        endcase
    endfunction

    // State and round registers; reset dominates any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            round_q <= 4'd0;
        end else begin
            state   <= state_nxt;
            round_q <= round_nxt;
        end
    end

    // Next-state: load only counts in IDLE/DONE, so a load while busy is dropped.
    always_comb begin
        state_nxt = state;
        round_nxt = round_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = INIT;
                    round_nxt = 4'd0;
                end
            end
            INIT: begin
                state_nxt = ROUND;
                round_nxt = 4'd1;
            end
            ROUND: begin
                if (round_q < NR_L) begin
                    round_nxt = round_q + 4'd1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (load) begin
                    state_nxt = INIT;
                    round_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = 4'd0;
            end
        endcase
    end

    // Moore outputs, decoded from state and round only.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        round    = round_q;
        init_sel = 1'b0;
        state_en = 1'b0;
        key_en   = 1'b0;
        mix_en   = 1'b0;
        rcon     = 8'h00;
        case (state)
            INIT: begin
                busy     = 1'b1;
                init_sel = 1'b1;
                state_en = 1'b1;
                key_en   = 1'b1;
            end
            ROUND: begin
                busy     = 1'b1;
                state_en = 1'b1;
                key_en   = 1'b1;
                // Final round skips MixColumns.
                mix_en   = (round_q < NR_L);
                rcon     = rc_of(round_q);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                round = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: a cycle-count reference model predicts
// every output each cycle, and a behavioural AES datapath driven by the DUT's
// controls checks the known-answer vector.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] S_INIT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] S_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] S_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       busy, done, init_sel, state_en, key_en, mix_en;
    logic [3:0] round;
    logic [7:0] rcon;

    int checks = 0;
    int errors = 0;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .reset(reset), .load(load),
        .busy(busy), .done(done), .round(round), .init_sel(init_sel),
        .state_en(state_en), .key_en(key_en), .mix_en(mix_en), .rcon(rcon)
    );

    always #5 clk = ~clk;

    // ---------------- AES helpers (behavioural) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p = x;
        logic [7:0] r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic mix);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) b[k] = sbox(byte_of(s, k));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[c*4+r] = b[((c + r) % 4)*4 + r];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                t[c*4]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[c*4+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[c*4+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[c*4+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = t[k];
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rw, tmp;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        rw = {w3[23:0], w3[31:24]};
        tmp = {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
        w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- Datapath model driven by DUT controls ----------------
    logic [127:0] dp_st = '0;
    logic [127:0] dp_rk = '0;
    int           dp_op = 0;   // 0 none, 1 init applied, 2 round-1 applied

    initial begin
        logic       l_en, l_init, l_mix;
        logic [7:0] l_rc;
        forever begin
            @(negedge clk);
            l_en = state_en & key_en; l_init = init_sel; l_mix = mix_en; l_rc = rcon;
            @(posedge clk);
            dp_op = 0;
            if (l_en === 1'b1) begin
                if (l_init === 1'b1) begin
                    dp_st = PT ^ KEY;
                    dp_rk = KEY;
                    dp_op = 1;
                end else begin
                    dp_rk = key_expand(dp_rk, l_rc);
                    dp_st = round_fn(dp_st, l_mix) ^ dp_rk;
                    if (l_rc == 8'h01) dp_op = 2;
                end
            end
        end
    end

    // ---------------- Reference model + scoreboard ----------------
    // t counts cycles since the operation started: -1 idle, 0 init,
    // 1..NR round cycles, NR+1 done.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] round;
        logic       init_sel;
        logic       state_en;
        logic       key_en;
        logic       mix_en;
        logic [7:0] rcon;
    } obs_t;

    obs_t exp_q[$];
    int   t = -1;
    logic [7:0] rc_tab [0:NR];
    int   aes_done_cnt = 0;

    function automatic obs_t predict(input int tt);
        obs_t o;
        o.busy     = (tt >= 0 && tt <= NR);
        o.done     = (tt == NR + 1);
        o.round    = (tt < 0) ? 4'd0 : (tt > NR) ? 4'(NR) : 4'(tt);
        o.init_sel = (tt == 0);
        o.state_en = o.busy;
        o.key_en   = o.busy;
        o.mix_en   = (tt >= 1 && tt < NR);
        o.rcon     = (tt >= 1 && tt <= NR) ? rc_tab[tt] : 8'h00;
        return o;
    endfunction

    task automatic step(input logic rst, input logic ld);
        reset = rst;
        load  = ld;
        @(posedge clk);
        if (rst) t = -1;
        else if (t == -1 || t == NR + 1) begin
            if (ld) t = 0;
        end else t = t + 1;
        exp_q.push_back(predict(t));
        #1;
    endtask

    // Monitor: one expected observation per cycle, plus AES known-answer points.
    initial begin
        obs_t e, a;
        logic prev_done = 1'b0;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {busy, done, round, init_sel, state_en, key_en, mix_en, rcon};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got busy=%b done=%b round=%0d init=%b sen=%b ken=%b mix=%b rcon=%h, expected busy=%b done=%b round=%0d init=%b sen=%b ken=%b mix=%b rcon=%h",
                             cyc, a.busy, a.done, a.round, a.init_sel, a.state_en, a.key_en, a.mix_en, a.rcon,
                             e.busy, e.done, e.round, e.init_sel, e.state_en, e.key_en, e.mix_en, e.rcon);
                end
            end
            if (dp_op == 1) begin
                checks++;
                if (dp_st !== S_INIT) begin
                    errors++;
                    $display("FAIL aes_init cyc %0d: got %h expected %h", cyc, dp_st, S_INIT);
                end
            end
            if (dp_op == 2) begin
                checks++;
                if (dp_st !== S_R1) begin
                    errors++;
                    $display("FAIL aes_round1 cyc %0d: got %h expected %h", cyc, dp_st, S_R1);
                end
            end
            if (done === 1'b1 && prev_done !== 1'b1) begin
                aes_done_cnt++;
                checks++;
                if (dp_st !== S_CT) begin
                    errors++;
                    $display("FAIL aes_cipher cyc %0d: got %h expected %h", cyc, dp_st, S_CT);
                end
            end
            prev_done = done;
        end
    end

    // ---------------- Stimulus ----------------
    initial begin
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int i = 2; i <= NR; i++) rc_tab[i] = xt(rc_tab[i-1]);

        // Reset, then idle.
        step(1, 0); step(1, 0);
        repeat (5) step(0, 0);

        // Single run, done held afterwards.
        step(0, 1);
        repeat (15) step(0, 0);

        // Load pulsed during round 4 is ignored.
        step(0, 1);
        repeat (4) step(0, 0);
        step(0, 1);
        repeat (10) step(0, 0);

        // Reset during round 6, then a clean run.
        step(0, 1);
        repeat (6) step(0, 0);
        step(1, 0);
        repeat (3) step(0, 0);
        step(0, 1);
        repeat (13) step(0, 0);

        // Load and reset on the same edge: reset wins.
        step(1, 1);
        step(0, 0);

        // Load held high: back-to-back runs.
        repeat (30) step(0, 1);
        repeat (3) step(0, 0);

        // Randomized load/reset.
        repeat (400) step(($urandom % 64) == 0, ($urandom % 6) == 0);
        repeat (14) step(0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (aes_done_cnt < 5) begin
            errors++;
            $display("FAIL aes_done_count: got %0d completions, expected at least 5", aes_done_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
